apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
Round-robin APB master that shares one APB bus between NUM_REQ local requesters. It sequences each granted request through the APB SETUP and ACCESS phases and waits for pready, with a timeout. It returns read data and error status to the winning requester. It sits between internal clients (config engines, test sequencers) and the dut_if APB bus feeding apb_slave.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for pready before forced error completion (>=2)

Ports:
pclk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held stable until matching rsp_done
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  flat-packed, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flat-packed write data
rsp_done  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (valid with rsp_done; 0 for writes and timeouts)
rsp_err  out  1  pslverr or timeout (valid with rsp_done)
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (rst=1 at an edge, including mid-transfer): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_done, rsp_rdata and rsp_err all 0; timeout counter 0; rr_last=NUM_REQ-1, so requester 0 has top priority first. An in-flight transfer is abandoned with no rsp_done.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req_valid & ~rsp_done. Masking rsp_done stops a just-completed request from being re-granted before the requester drops it.
  - If the eligible set is non-empty, the winner is the first set bit searching upward from rr_last+1, wrapping modulo NUM_REQ.
  - Latch the winner id, its write, addr and wdata onto pwrite, paddr and pwdata.
  - Drive psel=1, penable=0, then go to SETUP.
- SETUP (exactly 1 cycle): set penable=1 and go to ACCESS. paddr, pwrite and pwdata stay constant from SETUP through the end of ACCESS.
- ACCESS: the counter increments each cycle pready=0.
  - pready=1: psel=0, penable=0; rsp_done[id]=1; rsp_err=pslverr; rsp_rdata = prdata if read, else 0; rr_last=id; go to IDLE.
  - pready=0 and counter==TIMEOUT-1: same completion as above, but with rsp_err=1 and rsp_rdata=0.
  - The counter clears on leaving ACCESS.
- rsp_done is high only in the first IDLE cycle after completion. rsp_rdata and rsp_err hold until the next completion.
- Throughput: minimum 3 cycles per transfer (SETUP, ACCESS, IDLE turnaround); psel drops for at least 1 cycle between transfers.
- Changes to req_* of the granted requester after the grant are ignored. A request withdrawn before it is granted is simply dropped.
- Simultaneous requests: exactly one grant per arbitration. Under continuous load from all NUM_REQ requesters, no requester waits more than NUM_REQ-1 transfers.
- Widths: no arithmetic on data. Counter width is $clog2(TIMEOUT)+1.

Decomposition:
- Package apb_pkg: arb_state_t enum (IDLE, SETUP, ACCESS), plus APB_ADDR_W/APB_DATA_W defaults, shared with apb_slave's bench.
- One sub-module, rr_arbiter: a combinational round-robin pick from a request vector and rr_last, giving a one-hot grant plus an index. It is reusable for other shared resources.

Test Plan:
- Single write: req 0 writes addr 0x10, data 0xDEADBEEF, slave pready on the first ACCESS cycle -> psel at cycle 1, penable at cycle 2, rsp_done[0] at cycle 3, rsp_err=0; a subsequent read of 0x10 returns rsp_rdata=0xDEADBEEF.
- All 4 requesters assert reads of addr 0x1..0x4 together and hold them -> grants in order 0,1,2,3; each rsp_done pulses once; psel is low for 1 cycle between transfers.
- Fairness: req 1 and req 3 assert continuously -> grants alternate 1,3,1,3; a new req 0 is served within 2 transfers.
- Slave error: read addr 0x100 with pslverr=1 on pready -> rsp_err=1, rsp_done pulses, the arbiter returns to IDLE.
- Timeout: pready held 0 -> completion after exactly 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: rst=1 for 1 cycle -> psel and penable are 0 next cycle, no rsp_done; a held req_valid re-arbitrates starting from requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: arbiter FSM states and default bus widths.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } arb_state_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester-side and APB-side signals of the shared APB master.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_master_arb_if
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        rsp_done;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;

   logic [ADDR_W-1:0]         paddr;
   logic                      psel;
   logic                      penable;
   logic                      pwrite;
   logic [DATA_W-1:0]         pwdata;
   logic [DATA_W-1:0]         prdata;
   logic                      pready;
   logic                      pslverr;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output rsp_done, rsp_rdata, rsp_err,
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  rsp_done, rsp_rdata, rsp_err,
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_i, wrapping.
// Produces a one-hot grant, its index, and whether anything was picked.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      int               c;
      logic [IDX_W-1:0] ci;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      ci    = '0;
      for (int k = 1; k <= N; k++) begin
         c = int'(last_i) + k;
         if (c >= N) c = c - N;
         ci = IDX_W'(c);
         if (!any_o && req_i[ci]) begin
            any_o     = 1'b1;
            gnt_o[ci] = 1'b1;
            idx_o     = ci;
         end
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin APB master sharing one bus between NUM_REQ requesters,
// with SETUP/ACCESS sequencing and a pready timeout.
//
//   state  | meaning
//   IDLE   | arbitrate; rsp_done pulses here in the first cycle after completion
//   SETUP  | psel=1, penable=0, one cycle
//   ACCESS | psel=1, penable=1, wait for pready or timeout
module apb_master_arb
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 16
) (
   input logic               pclk,
   input logic               rst,
   apb_master_arb_if.master  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   arb_state_t          state_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [IDX_W-1:0]    id_q;
   logic [IDX_W-1:0]    rr_last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic [NUM_REQ-1:0]  rsp_done_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_err_q;

   logic [NUM_REQ-1:0]  elig_d;
   logic [NUM_REQ-1:0]  gnt_d;
   logic [IDX_W-1:0]    win_d;
   logic                any_d;

   // A requester whose response is pulsing this cycle has not yet dropped its request.
   assign elig_d = bus.req_valid & ~rsp_done_q;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
      .req_i  (elig_d),
      .last_i (rr_last_q),
      .gnt_o  (gnt_d),
      .idx_o  (win_d),
      .any_o  (any_d)
   );

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         id_q        <= '0;
         rr_last_q   <= IDX_W'(NUM_REQ - 1);
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_done_q  <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rsp_done_q <= '0;
               if (any_d) begin
                  gnt_q     <= gnt_d;
                  id_q      <= win_d;
                  pwrite_q  <= bus.req_write[win_d];
                  paddr_q   <= bus.req_addr[int'(win_d)*ADDR_W +: ADDR_W];
                  pwdata_q  <= bus.req_wdata[int'(win_d)*DATA_W +: DATA_W];
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  psel_q     <= 1'b0;
                  penable_q  <= 1'b0;
                  rsp_done_q <= gnt_q;
                  rr_last_q  <= id_q;
                  cnt_q      <= '0;
                  state_q    <= IDLE;
                  if (bus.pready) begin
                     rsp_err_q   <= bus.pslverr;
                     rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                  end else begin
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_done  = rsp_done_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_master_arb;
   import apb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   apb_master_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bif ();

   apb_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bif.master)
   );

   initial forever #5 pclk = ~pclk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: transfer in flight and its age in cycles since the grant (0 = setup)
   bit            m_busy;
   bit            m_fresh;
   int            m_age;
   int            m_id;
   logic          m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  m_done;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   int            m_last;

   int sl_mode;   // 0 ready at once, 1 random waits, 2 never ready
   int sl_err;    // 0 never, 1 always, 2 occasionally
   logic [DW-1:0] mem [logic [AW-1:0]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return '0;
   endfunction

   task automatic model_complete(input logic err, input logic [DW-1:0] rd);
      m_busy  = 1'b0;
      m_done  = '0;
      m_done[m_id] = 1'b1;
      m_err   = err;
      m_rdata = rd;
      m_last  = m_id;
   endtask

   // Predicts the state after the coming rising edge from the inputs now applied.
   task automatic model_advance();
      logic [N-1:0] elig;
      int best, bestd, d;
      if (rst) begin
         m_busy = 0; m_fresh = 1; m_age = 0; m_id = 0;
         m_write = 0; m_addr = '0; m_wdata = '0;
         m_done = '0; m_rdata = '0; m_err = 0; m_last = N - 1;
      end else if (!m_busy) begin
         elig   = bif.req_valid & ~m_done;
         m_done = '0;
         best   = -1;
         bestd  = N;
         for (int i = 0; i < N; i++) begin
            d = (i - m_last - 1 + 2 * N) % N;
            if (elig[i] && d < bestd) begin
               best  = i;
               bestd = d;
            end
         end
         if (best >= 0) begin
            m_busy  = 1; m_fresh = 0; m_age = 0; m_id = best;
            m_write = bif.req_write[best];
            m_addr  = bif.req_addr[best*AW +: AW];
            m_wdata = bif.req_wdata[best*DW +: DW];
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (bif.pready) begin
         model_complete(bif.pslverr, m_write ? '0 : bif.prdata);
      end else if (m_age == TO) begin
         model_complete(1'b1, '0);
      end else begin
         m_age++;
      end
   endtask

   task automatic slave_drive();
      logic r;
      if (bif.psel === 1'b1 && bif.penable === 1'b1) begin
         case (sl_mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 2) == 0);
            default: r = 1'b0;
         endcase
         bif.pready  = r;
         bif.pslverr = r && (sl_err == 1 || (sl_err == 2 && $urandom_range(0, 7) == 0));
         bif.prdata  = r ? mem_rd(bif.paddr) : DW'($urandom());
      end else begin
         bif.pready  = 1'($urandom_range(0, 1));
         bif.pslverr = 1'($urandom_range(0, 1));
         bif.prdata  = DW'($urandom());
      end
   endtask

   task automatic compare();
      chk("psel", 64'(bif.psel), 64'(m_busy));
      chk("penable", 64'(bif.penable), 64'(m_busy && m_age >= 1));
      chk("rsp_done", 64'(bif.rsp_done), 64'(m_done));
      chk("rsp_rdata", 64'(bif.rsp_rdata), 64'(m_rdata));
      chk("rsp_err", 64'(bif.rsp_err), 64'(m_err));
      if (m_busy || m_fresh) begin
         chk("paddr", 64'(bif.paddr), 64'(m_addr));
         chk("pwrite", 64'(bif.pwrite), 64'(m_write));
         chk("pwdata", 64'(bif.pwdata), 64'(m_wdata));
      end
   endtask

   task automatic tick();
      slave_drive();
      model_advance();
      if (bif.psel === 1'b1 && bif.penable === 1'b1 && bif.pready && bif.pwrite === 1'b1 && !bif.pslverr)
         mem[bif.paddr] = bif.pwdata;
      @(negedge pclk);
      compare();
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] dat);
      bif.req_valid[i]         = v;
      bif.req_write[i]         = w;
      bif.req_addr[i*AW +: AW] = a;
      bif.req_wdata[i*DW +: DW] = dat;
   endtask

   task automatic new_req(input int i);
      set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 4), DW'($urandom()));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bif.req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(output logic [N-1:0] d, input int budget);
      bit got;
      got = 0;
      d   = '0;
      for (int k = 0; k < budget && !got; k++) begin
         tick();
         if (bif.rsp_done != '0) begin
            got = 1;
            d   = bif.rsp_done;
         end
      end
      chk("wait_done_bound", 64'(got), 64'd1);
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < N; i++) begin
         if (m_done[i]) begin
            if ($urandom_range(0, 1) == 1) new_req(i);
            else bif.req_valid[i] = 1'b0;
         end else if (!bif.req_valid[i]) begin
            if ($urandom_range(0, 3) == 0) new_req(i);
         end else if (m_busy && m_id == i) begin
            if ($urandom_range(0, 4) == 0) new_req(i);
         end else if ($urandom_range(0, 29) == 0) begin
            bif.req_valid[i] = 1'b0;
         end
      end
   endtask

   initial begin
      logic [N-1:0] d;
      int cnt, others;
      bit got;

      bif.req_valid = '0; bif.req_write = '0; bif.req_addr = '0; bif.req_wdata = '0;
      bif.pready = 0; bif.pslverr = 0; bif.prdata = '0;
      sl_mode = 0; sl_err = 0;

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_psel", 64'(bif.psel), 64'd0);
      chk("reset_penable", 64'(bif.penable), 64'd0);
      chk("reset_paddr", 64'(bif.paddr), 64'd0);
      chk("reset_rsp_done", 64'(bif.rsp_done), 64'd0);

      // single write then read back
      set_req(0, 1, 1, 32'h10, 32'hDEADBEEF);
      tick();
      chk("wr_c1_psel", 64'(bif.psel), 64'd1);
      chk("wr_c1_penable", 64'(bif.penable), 64'd0);
      chk("wr_c1_paddr", 64'(bif.paddr), 64'h10);
      tick();
      chk("wr_c2_penable", 64'(bif.penable), 64'd1);
      tick();
      chk("wr_c3_done", 64'(bif.rsp_done), 64'b0001);
      chk("wr_c3_err", 64'(bif.rsp_err), 64'd0);
      chk("wr_c3_psel", 64'(bif.psel), 64'd0);
      set_req(0, 0, 0, 32'h10, 32'h0);
      tick();
      set_req(0, 1, 0, 32'h10, 32'h0);
      wait_done(d, 10);
      chk("rd_done", 64'(d), 64'b0001);
      chk("rd_rdata", 64'(bif.rsp_rdata), 64'hDEADBEEF);
      set_req(0, 0, 0, 0, 0);

      // all four at once: served 0,1,2,3
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i + 1), 0);
      for (int k = 0; k < N; k++) begin
         wait_done(d, 12);
         chk("all4_order", 64'(d), 64'(1 << k));
         bif.req_valid = bif.req_valid & ~d;
      end

      // fairness between 1 and 3, then a late requester 0
      do_reset();
      set_req(1, 1, 0, 32'h8, 0);
      set_req(3, 1, 1, 32'hC, 32'h33);
      for (int k = 0; k < 4; k++) begin
         wait_done(d, 12);
         chk("fair_alt", 64'(d), (k % 2 == 0) ? 64'b0010 : 64'b1000);
      end
      set_req(0, 1, 0, 32'h0, 0);
      others = 0;
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
         wait_done(d, 12);
         if (d[0]) got = 1;
         else others++;
      end
      chk("fair_req0_within_2", 64'(got && others <= 2), 64'd1);
      bif.req_valid = '0;

      // slave error
      do_reset();
      sl_err = 1;
      set_req(0, 1, 0, 32'h100, 0);
      wait_done(d, 10);
      chk("slverr_done", 64'(d), 64'b0001);
      chk("slverr_err", 64'(bif.rsp_err), 64'd1);
      bif.req_valid = '0;
      sl_err = 0;
      tick();
      chk("slverr_idle_psel", 64'(bif.psel), 64'd0);
      chk("slverr_idle_done", 64'(bif.rsp_done), 64'd0);

      // timeout after exactly TO access cycles
      do_reset();
      sl_mode = 2;
      set_req(2, 1, 0, 32'h20, 0);
      cnt = 0;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         if (bif.penable === 1'b1) cnt++;
         if (bif.rsp_done != '0) got = 1;
      end
      chk("timeout_bound", 64'(got), 64'd1);
      chk("timeout_access_cycles", 64'(cnt), 64'd16);
      chk("timeout_done", 64'(bif.rsp_done), 64'b0100);
      chk("timeout_err", 64'(bif.rsp_err), 64'd1);
      chk("timeout_rdata", 64'(bif.rsp_rdata), 64'd0);
      bif.req_valid = '0;
      sl_mode = 0;
      set_req(1, 1, 1, 32'h24, 32'h1234);
      wait_done(d, 10);
      chk("after_timeout_done", 64'(d), 64'b0010);
      chk("after_timeout_err", 64'(bif.rsp_err), 64'd0);
      bif.req_valid = '0;

      // reset during access restarts priority at requester 0
      do_reset();
      set_req(2, 1, 0, 32'h40, 0);
      wait_done(d, 10);
      bif.req_valid = '0;
      sl_mode = 2;
      set_req(3, 1, 0, 32'h44, 0);
      got = 0;
      for (int k = 0; k < 6 && !got; k++) begin
         tick();
         if (bif.penable === 1'b1) got = 1;
      end
      chk("midrst_reach_access", 64'(got), 64'd1);
      rst = 1'b1;
      set_req(2, 1, 0, 32'h48, 0);
      tick();
      rst = 1'b0;
      chk("midrst_psel", 64'(bif.psel), 64'd0);
      chk("midrst_penable", 64'(bif.penable), 64'd0);
      chk("midrst_done", 64'(bif.rsp_done), 64'd0);
      sl_mode = 0;
      wait_done(d, 10);
      chk("midrst_first_grant", 64'(d), 64'b0100);
      bif.req_valid = '0;

      // randomized traffic
      sl_err = 2;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 100 == 0) begin
            cnt = int'($urandom_range(0, 9));
            sl_mode = (cnt < 3) ? 0 : (cnt < 9) ? 1 : 2;
         end
         rst = ($urandom_range(0, 199) == 0);
         rand_reqs();
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
